decode_field_packer: RTL and testbench
======================================

DECODE_FIELD_PACKER -- requirements
Module: decode_field_packer

Interface
- REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
- REQ-003 SHALL have port valid_in, input, 1 bit: capture enable for the instruction and control fields.
- REQ-004 SHALL have port instruction, input, 32 bits: raw MIPS instruction word.
- REQ-005 SHALL have control-field inputs: af 4, i 1, alu_mux_sel 1, shift_type 3, cad 5, gp_we 1, gp_mux_sel 3, bf 4, pc_mux_select 2, spr_mux_sel 1, mem_wren 1, mem_rren 1.
- REQ-006 SHALL have split-field outputs: opc 6, rs 5, rt 5, rd 5, sa 5, fun 6, imm 16, iindex 26.
- REQ-007 SHALL have port packed_out, output, 42 bits: the packed control word.
- REQ-008 SHALL have port valid_out, output, 1 bit: outputs hold a captured word.

Function
- REQ-009 Split: opc=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], sa=[10:6], fun=[5:0], imm=[15:0], iindex=[25:0].
- REQ-010 Pack order, MSB first: af[41:38], i[37], alu_mux_sel[36], shift_type[35:33], cad[32:28], gp_we[27], gp_mux_sel[26:24], bf[23:20], pc_mux_select[19:18], spr_mux_sel[17], mem_wren[16], mem_rren[15], rs[14:10], rt[9:5], rd[4:0].
- REQ-011 rs/rt/rd in packed_out SHALL come from the same captured instruction, never from a separate input.
- REQ-012 Latency SHALL be one cycle: a valid_in=1 edge registers all split fields and packed_out; valid_out=1 on the next cycle.
- REQ-013 valid_in=0 SHALL hold all data outputs unchanged and clear valid_out at the next edge.
- REQ-014 Back-to-back valid_in SHALL give one new output word per cycle, with no bubbles.
- REQ-015 No arithmetic SHALL be performed: pure bit-field copy, zero padding nowhere, widths exact.

Reset
- REQ-016 rst=1 SHALL asynchronously force every output to 0, including valid_out and packed_out.
- REQ-017 Reset asserted mid-stream SHALL discard the in-flight word; the first capture after release SHALL occur on the first edge with rst=0 and valid_in=1.

Configuration
- REQ-018 Macro DECODE_IMM_SEXT_EN defined SHALL add output imm_sext, 32 bits = {{16{instr[15]}}, instr[15:0]}, registered with the other fields and reset to 0.
- REQ-019 Without DECODE_IMM_SEXT_EN the port SHALL not exist, and all other behaviour SHALL be identical.

Structure
- REQ-020 Shared package SHALL hold: field widths, the PACKED_W=42 constant, and the bit-position constants of REQ-010.
- REQ-021 Combinational field extraction SHALL be one sub-module, instr_splitter, instantiated once; the top holds registers and packing.

Verification
- REQ-022 Reset: rst=1 with valid_in=1, instruction=32'hFFFFFFFF -> all outputs 0 immediately, without waiting for a clock edge.
- REQ-023 Capture instruction=32'h012A4020 with all control inputs 0 -> next cycle opc=0, rs=9, rt=10, rd=8, sa=0, fun=6'h20, imm=16'h4020, packed_out=42'h000_0000_2548, valid_out=1.
- REQ-024 Capture instruction=0, af=4'hA, others 0 -> packed_out=42'h280_0000_0000; then set all control inputs to all-ones, still instruction=0 -> packed_out=42'h3FF_FFFF_8000.
- REQ-025 Capture instruction=32'h8C220004, then valid_in=0 for 3 cycles with a changing instruction -> opc=6'h23, rs=1, rt=2, imm=4 held; valid_out=0 after the first idle edge.
- REQ-026 With DECODE_IMM_SEXT_EN: instruction=32'h2021FFFF -> imm_sext=32'hFFFFFFFF; instruction=32'h20217FFF -> imm_sext=32'h00007FFF.

Source files
------------

// File: rtl/decode_field_packer_pkg.sv
// decode_field_packer_pkg: field widths, packed-word layout and the split-field
// bundle shared by the decoder field packer and its splitter.
// Optional feature macro: DECODE_IMM_SEXT_EN (adds the sign-extended immediate).
package decode_field_packer_pkg;

   // instruction split widths
   localparam int INSTR_W = 32;
   localparam int OPC_W   = 6;
   localparam int REG_W   = 5;
   localparam int SA_W    = 5;
   localparam int FUN_W   = 6;
   localparam int IMM_W   = 16;
   localparam int IIDX_W  = 26;

   // control field widths
   localparam int AF_W    = 4;
   localparam int SHT_W   = 3;
   localparam int CAD_W   = 5;
   localparam int GPMUX_W = 3;
   localparam int BF_W    = 4;
   localparam int PCMUX_W = 2;

   // packed control word layout, MSB first
   localparam int PACKED_W    = 42;
   localparam int AF_LSB      = 38;
   localparam int I_BIT       = 37;
   localparam int ALUMUX_BIT  = 36;
   localparam int SHT_LSB     = 33;
   localparam int CAD_LSB     = 28;
   localparam int GPWE_BIT    = 27;
   localparam int GPMUX_LSB   = 24;
   localparam int BF_LSB      = 20;
   localparam int PCMUX_LSB   = 18;
   localparam int SPRMUX_BIT  = 17;
   localparam int MEMWR_BIT   = 16;
   localparam int MEMRD_BIT   = 15;
   localparam int RS_LSB      = 10;
   localparam int RT_LSB      = 5;
   localparam int RD_LSB      = 0;

   // all fields carved out of one instruction word
   typedef struct packed {
      logic [OPC_W-1:0]  opc;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [SA_W-1:0]   sa;
      logic [FUN_W-1:0]  fun;
      logic [IMM_W-1:0]  imm;
      logic [IIDX_W-1:0] iindex;
   } instr_fields_t;

endpackage

// File: rtl/decode_field_packer_instr_splitter.sv
// instr_splitter: purely combinational carving of a MIPS instruction into its
// R/I/J-format fields. Overlapping fields (imm vs rd/sa/fun, iindex vs rs/rt/imm)
// are all produced; the consumer picks what the format needs.
// Optional feature macro: DECODE_IMM_SEXT_EN (adds o_imm_sext-style output imm_sext).
module instr_splitter
   import decode_field_packer_pkg::*;
(
   input  logic [INSTR_W-1:0] instruction,
`ifdef DECODE_IMM_SEXT_EN
   output logic [INSTR_W-1:0] imm_sext,
`endif
   output instr_fields_t      fields
);

   // straight bit-field copy, no arithmetic
   always_comb begin
      fields        = '0;
      fields.opc    = instruction[31:26];
      fields.rs     = instruction[25:21];
      fields.rt     = instruction[20:16];
      fields.rd     = instruction[15:11];
      fields.sa     = instruction[10:6];
      fields.fun    = instruction[5:0];
      fields.imm    = instruction[15:0];
      fields.iindex = instruction[25:0];
   end

`ifdef DECODE_IMM_SEXT_EN
   assign imm_sext = {{(INSTR_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};
`endif

endmodule

// File: rtl/decode_field_packer.sv
// decode_field_packer: registers the split instruction fields and a 42-bit packed
// control word one cycle after valid_in. rs/rt/rd in the packed word come from
// the same captured instruction as the split outputs. Data outputs hold while
// valid_in is low; valid_out marks a freshly captured word.
// Optional feature macro: DECODE_IMM_SEXT_EN (adds registered output imm_sext).
module decode_field_packer
   import decode_field_packer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_in,
   input  logic [INSTR_W-1:0]  instruction,
   input  logic [AF_W-1:0]     af,
   input  logic                i,
   input  logic                alu_mux_sel,
   input  logic [SHT_W-1:0]    shift_type,
   input  logic [CAD_W-1:0]    cad,
   input  logic                gp_we,
   input  logic [GPMUX_W-1:0]  gp_mux_sel,
   input  logic [BF_W-1:0]     bf,
   input  logic [PCMUX_W-1:0]  pc_mux_select,
   input  logic                spr_mux_sel,
   input  logic                mem_wren,
   input  logic                mem_rren,
   output logic [OPC_W-1:0]    opc,
   output logic [REG_W-1:0]    rs,
   output logic [REG_W-1:0]    rt,
   output logic [REG_W-1:0]    rd,
   output logic [SA_W-1:0]     sa,
   output logic [FUN_W-1:0]    fun,
   output logic [IMM_W-1:0]    imm,
   output logic [IIDX_W-1:0]   iindex,
`ifdef DECODE_IMM_SEXT_EN
   output logic [INSTR_W-1:0]  imm_sext,
`endif
   output logic [PACKED_W-1:0] packed_out,
   output logic                valid_out
);

   instr_fields_t       w_fields;
   logic [PACKED_W-1:0] w_packed;
   instr_fields_t       r_fields;
   logic [PACKED_W-1:0] r_packed;
   logic                r_valid;
`ifdef DECODE_IMM_SEXT_EN
   logic [INSTR_W-1:0]  w_imm_sext;
   logic [INSTR_W-1:0]  r_imm_sext;
`endif

   instr_splitter u_split (
      .instruction (instruction),
`ifdef DECODE_IMM_SEXT_EN
      .imm_sext    (w_imm_sext),
`endif
      .fields      (w_fields)
   );

   // assemble the control word; register indices come from the splitter
   always_comb begin
      w_packed                               = '0;
      w_packed[AF_LSB    +: AF_W]            = af;
      w_packed[I_BIT]                        = i;
      w_packed[ALUMUX_BIT]                   = alu_mux_sel;
      w_packed[SHT_LSB   +: SHT_W]           = shift_type;
      w_packed[CAD_LSB   +: CAD_W]           = cad;
      w_packed[GPWE_BIT]                     = gp_we;
      w_packed[GPMUX_LSB +: GPMUX_W]         = gp_mux_sel;
      w_packed[BF_LSB    +: BF_W]            = bf;
      w_packed[PCMUX_LSB +: PCMUX_W]         = pc_mux_select;
      w_packed[SPRMUX_BIT]                   = spr_mux_sel;
      w_packed[MEMWR_BIT]                    = mem_wren;
      w_packed[MEMRD_BIT]                    = mem_rren;
      w_packed[RS_LSB    +: REG_W]           = w_fields.rs;
      w_packed[RT_LSB    +: REG_W]           = w_fields.rt;
      w_packed[RD_LSB    +: REG_W]           = w_fields.rd;
   end

   // capture on valid_in, hold data otherwise; valid_out follows valid_in by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fields   <= '0;
         r_packed   <= '0;
         r_valid    <= 1'b0;
`ifdef DECODE_IMM_SEXT_EN
         r_imm_sext <= '0;
`endif
      end else begin
         r_valid <= valid_in;
         if (valid_in) begin
            r_fields   <= w_fields;
            r_packed   <= w_packed;
`ifdef DECODE_IMM_SEXT_EN
            r_imm_sext <= w_imm_sext;
`endif
         end
      end
   end

   assign opc        = r_fields.opc;
   assign rs         = r_fields.rs;
   assign rt         = r_fields.rt;
   assign rd         = r_fields.rd;
   assign sa         = r_fields.sa;
   assign fun        = r_fields.fun;
   assign imm        = r_fields.imm;
   assign iindex     = r_fields.iindex;
   assign packed_out = r_packed;
   assign valid_out  = r_valid;
`ifdef DECODE_IMM_SEXT_EN
   assign imm_sext   = r_imm_sext;
`endif

endmodule

// File: tb/tb_decode_field_packer.sv
// tb_decode_field_packer: directed and randomized checks of decode_field_packer
// against a field-level reference model (shift/mask arithmetic on the instruction
// and control values). Inputs change on the falling edge, outputs are sampled
// 1 time unit after the rising edge.
module tb_decode_field_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] instruction = '0;
   logic [3:0]  af = '0;
   logic        i = 1'b0;
   logic        alu_mux_sel = 1'b0;
   logic [2:0]  shift_type = '0;
   logic [4:0]  cad = '0;
   logic        gp_we = 1'b0;
   logic [2:0]  gp_mux_sel = '0;
   logic [3:0]  bf = '0;
   logic [1:0]  pc_mux_select = '0;
   logic        spr_mux_sel = 1'b0;
   logic        mem_wren = 1'b0;
   logic        mem_rren = 1'b0;

   logic [5:0]  opc;
   logic [4:0]  rs, rt, rd, sa;
   logic [5:0]  fun;
   logic [15:0] imm;
   logic [25:0] iindex;
   logic [41:0] packed_out;
   logic        valid_out;
`ifdef DECODE_IMM_SEXT_EN
   logic [31:0] imm_sext;
`endif

   int checks = 0;
   int errors = 0;

   // reference model state: what the outputs should show
   logic [31:0] m_instr;
   logic [41:0] m_packed;
   logic        m_valid;

   always #5 clk = ~clk;

   decode_field_packer dut (
      .clk           (clk),
      .rst           (rst),
      .valid_in      (valid_in),
      .instruction   (instruction),
      .af            (af),
      .i             (i),
      .alu_mux_sel   (alu_mux_sel),
      .shift_type    (shift_type),
      .cad           (cad),
      .gp_we         (gp_we),
      .gp_mux_sel    (gp_mux_sel),
      .bf            (bf),
      .pc_mux_select (pc_mux_select),
      .spr_mux_sel   (spr_mux_sel),
      .mem_wren      (mem_wren),
      .mem_rren      (mem_rren),
      .opc           (opc),
      .rs            (rs),
      .rt            (rt),
      .rd            (rd),
      .sa            (sa),
      .fun           (fun),
      .imm           (imm),
      .iindex        (iindex),
`ifdef DECODE_IMM_SEXT_EN
      .imm_sext      (imm_sext),
`endif
      .packed_out    (packed_out),
      .valid_out     (valid_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // control word as the spec lays it out: each field times its bit weight
   function automatic logic [41:0] ref_pack(input logic [31:0] ins);
      logic [63:0] v;
      v = 64'(af) * (64'd1 << 38)
        + 64'(i) * (64'd1 << 37)
        + 64'(alu_mux_sel) * (64'd1 << 36)
        + 64'(shift_type) * (64'd1 << 33)
        + 64'(cad) * (64'd1 << 28)
        + 64'(gp_we) * (64'd1 << 27)
        + 64'(gp_mux_sel) * (64'd1 << 24)
        + 64'(bf) * (64'd1 << 20)
        + 64'(pc_mux_select) * (64'd1 << 18)
        + 64'(spr_mux_sel) * (64'd1 << 17)
        + 64'(mem_wren) * (64'd1 << 16)
        + 64'(mem_rren) * (64'd1 << 15)
        + 64'((ins >> 21) & 32'h1F) * 1024
        + 64'((ins >> 16) & 32'h1F) * 32
        + 64'((ins >> 11) & 32'h1F);
      return v[41:0];
   endfunction

   task automatic check_model(input string tag);
      chk({tag, "_opc"},    64'(opc),    64'((m_instr >> 26) & 32'h3F));
      chk({tag, "_rs"},     64'(rs),     64'((m_instr >> 21) & 32'h1F));
      chk({tag, "_rt"},     64'(rt),     64'((m_instr >> 16) & 32'h1F));
      chk({tag, "_rd"},     64'(rd),     64'((m_instr >> 11) & 32'h1F));
      chk({tag, "_sa"},     64'(sa),     64'((m_instr >> 6) & 32'h1F));
      chk({tag, "_fun"},    64'(fun),    64'(m_instr & 32'h3F));
      chk({tag, "_imm"},    64'(imm),    64'(m_instr & 32'hFFFF));
      chk({tag, "_iindex"}, 64'(iindex), 64'(m_instr & 32'h03FF_FFFF));
      chk({tag, "_packed"}, 64'(packed_out), 64'(m_packed));
      chk({tag, "_valid"},  64'(valid_out),  64'(m_valid));
`ifdef DECODE_IMM_SEXT_EN
      chk({tag, "_sext"},   64'(imm_sext),
          64'((m_instr & 32'h8000) != 0 ? (m_instr | 32'hFFFF_0000) : (m_instr & 32'hFFFF)));
`endif
   endtask

   // advance one clock: update model from inputs seen at the edge, then check
   task automatic step(input string tag);
      if (rst) begin
         m_instr = '0; m_packed = '0; m_valid = 1'b0;
      end else begin
         m_valid = valid_in;
         if (valid_in) begin
            m_instr  = instruction;
            m_packed = ref_pack(instruction);
         end
      end
      @(posedge clk); #1;
      check_model(tag);
      @(negedge clk);
   endtask

   task automatic set_ctrl(input logic [26:0] c);
      {af, i, alu_mux_sel, shift_type, cad, gp_we, gp_mux_sel, bf,
       pc_mux_select, spr_mux_sel, mem_wren, mem_rren} = c;
   endtask

   initial begin
      m_instr = '0; m_packed = '0; m_valid = 1'b0;
      // load something nonzero, then reset asynchronously mid-cycle
      @(negedge clk);
      valid_in = 1'b1; instruction = 32'hFFFF_FFFF; set_ctrl('1);
      @(posedge clk); #2;
      rst = 1'b1; #1;
      m_instr = '0; m_packed = '0; m_valid = 1'b0;
      check_model("async_rst");
      @(negedge clk);
      step("rst_hold");
      rst = 1'b0; valid_in = 1'b0; set_ctrl('0);
      step("post_rst_idle");

      // known-answer: add $8,$9,$10
      valid_in = 1'b1; instruction = 32'h012A_4020;
      step("kat_add");
      chk("kat_add_rs_lit", 64'(rs), 64'd9);
      chk("kat_add_rt_lit", 64'(rt), 64'd10);
      chk("kat_add_rd_lit", 64'(rd), 64'd8);
      chk("kat_add_packed_lit", 64'(packed_out), 64'h000_0000_2548);

      // control-field placement
      instruction = '0; af = 4'hA;
      step("kat_af");
      chk("kat_af_packed_lit", 64'(packed_out), 64'h280_0000_0000);
      set_ctrl('1);
      step("kat_ones");
      chk("kat_ones_packed_lit", 64'(packed_out), 64'h3FF_FFFF_8000);

      // lw then three idle cycles with a changing instruction
      set_ctrl('0); instruction = 32'h8C22_0004;
      step("lw_cap");
      valid_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         instruction = $urandom; set_ctrl(27'($urandom));
         step("lw_hold");
      end
      chk("lw_hold_opc_lit", 64'(opc), 64'h23);
      chk("lw_hold_imm_lit", 64'(imm), 64'd4);

`ifdef DECODE_IMM_SEXT_EN
      valid_in = 1'b1; instruction = 32'h2021_FFFF;
      step("sext_neg");
      chk("sext_neg_lit", 64'(imm_sext), 64'hFFFF_FFFF);
      instruction = 32'h2021_7FFF;
      step("sext_pos");
      chk("sext_pos_lit", 64'(imm_sext), 64'h0000_7FFF);
`endif

      // back-to-back captures, no bubbles
      valid_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         instruction = $urandom; set_ctrl(27'($urandom));
         step("b2b");
      end

      // random valid pattern
      for (int k = 0; k < 60; k++) begin
         valid_in = 1'($urandom_range(0, 1));
         instruction = $urandom; set_ctrl(27'($urandom));
         step("rand");
      end

      // reset mid-stream discards the in-flight word
      valid_in = 1'b1; instruction = 32'hDEAD_BEEF; set_ctrl(27'($urandom));
      #2 rst = 1'b1; #1;
      m_instr = '0; m_packed = '0; m_valid = 1'b0;
      check_model("mid_rst");
      @(negedge clk);
      rst = 1'b0; instruction = 32'h1234_5678;
      step("first_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
